cmt_regif: RTL and testbench
============================

CMT_REGIF -- requirements
Module: cmt_regif

Interface
REQ-001 SHALL have parameter COR_RST, default 16'hFFFF, the reset value of both compare-constant registers.
REQ-002 SHALL have port clk, input, 1, the system clock (50 MHz); all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have port ce_i, input, 1, the access request; it is held until ack_o is seen.
REQ-005 SHALL have port we_i, input, 1, where 1 means write and 0 means read; it is qualified by ce_i.
REQ-006 SHALL have port addr_i, input, 3, the register word index.
REQ-007 SHALL have port wdata_i, input, 16, the write data.
REQ-008 SHALL have port rdata_o, output, 16, the read data; it is valid only while ack_o=1 and is 0 otherwise.
REQ-009 SHALL have port ack_o, output, 1, a one-cycle access-complete pulse.
REQ-010 SHALL have ports str0_o and str1_o, output, 1 each, the timer start enables.
REQ-011 SHALL have ports cks0_o and cks1_o, output, 2 each, the clock-divider selects (00=/8, 01=/32, 10=/128, 11=/512).
REQ-012 SHALL have ports const0_o and const1_o, output, 16 each, the compare constants.
REQ-013 SHALL have ports set_cnt0_o and set_cnt1_o, output, 1 each, one-cycle counter-load pulses.
REQ-014 SHALL have ports wdata_cnt0_o and wdata_cnt1_o, output, 16 each, the counter load values.
REQ-015 SHALL have ports cmf0_i and cmf1_i, input, 1 each, the timer compare-match pulses.
REQ-016 SHALL have ports cnt0_i and cnt1_i, input, 16 each, the live timer counts.
REQ-017 SHALL have ports irq0_o and irq1_o, output, 1 each, the level interrupt requests.

Function
REQ-018 SHALL use this register map by addr_i:
- 0 CMSTR: bit0 STR0, bit1 STR1.
- 1 CMCSR0: bit7 CMF, bit6 CMIE, bits1:0 CKS.
- 2 CMCNT0.
- 3 CMCOR0.
- 4 CMCSR1, 5 CMCNT1, 6 CMCOR1: same layouts as 1-3, for channel 1.
- 7 reserved: reads 0, writes ignored.
- Unused bits read 0.
REQ-019 SHALL accept an access when ce_i=1 and ack_o=0, and SHALL assert ack_o on the following cycle for exactly one cycle (fixed latency of 1).
REQ-020 SHALL NOT accept a new access in the cycle ack_o=1, so back-to-back accesses are spaced at least 2 cycles apart.
REQ-021 SHALL apply every register write on the same clock edge that raises ack_o.
REQ-022 SHALL on read drive rdata_o while ack_o=1, using the value sampled at the accept edge; CMCNTn reads return cnt{n}_i sampled at that edge.
REQ-023 SHALL on a write to CMCNTn drive set_cnt{n}_o=1 for exactly the ack cycle, with wdata_cnt{n}_o equal to the written data; wdata_cnt{n}_o holds its last value afterwards.
REQ-024 SHALL drive str{n}_o, cks{n}_o and const{n}_o directly from register bits, with no additional pipeline stage.
REQ-025 SHALL set CMFn on any cycle in which cmf{n}_i=1; a CMFn that is already 1 stays 1.
REQ-026 SHALL set an internal armed bit ARMn when CMCSRn is read while CMFn=1, and SHALL clear ARMn whenever CMFn is newly set.
REQ-027 SHALL clear CMFn on a CMCSRn write with bit7=0 only if ARMn=1; a write of bit7=1 leaves CMFn unchanged.
REQ-028 SHALL give set priority over clear when cmf{n}_i=1 coincides with the clearing write, leaving CMFn=1 and ARMn=0.
REQ-029 SHALL update CMIE and CKS on every CMCSRn write, independently of the CMF rule.
REQ-030 SHALL drive irq{n}_o = CMFn & CMIEn as registered state with no combinational path from inputs, so irq follows a cmf{n}_i pulse by 1 cycle.
REQ-031 SHALL operate both channels fully independently, so simultaneous events on both channels are all honoured.

Reset
REQ-032 SHALL on rst_n=0 immediately:
- clear STR, CMF, ARM and CMIE to 0;
- clear CKS to 00;
- set CMCOR0/1 to COR_RST;
- clear ack_o, rdata_o, set_cnt0_o/set_cnt1_o and irq0_o/irq1_o to 0;
- clear wdata_cnt0_o/wdata_cnt1_o to 0.
REQ-033 SHALL discard, on reset, an access accepted but not yet acknowledged, with no ack_o and no register effect.

Verification
REQ-034 SHALL be verified by a write of 16'h0003 to addr 0 -> the next cycle shows ack_o=1, str0_o=1 and str1_o=1; a read of addr 0 returns 16'h0003.
REQ-035 SHALL be verified by a write of 16'h1234 to addr 5 -> set_cnt1_o=1 for exactly 1 cycle with wdata_cnt1_o=16'h1234, and set_cnt0_o stays 0.
REQ-036 SHALL be verified by CMIE0=1 with a one-cycle pulse on cmf0_i -> irq0_o=1 the next cycle; a read of addr 1 returns bit7=1; a write of 16'h0040 then gives CMF0=0 and irq0_o=0.
REQ-037 SHALL be verified by CMF0=1 with a write of 16'h0040 to addr 1 without a prior read -> CMF0 stays 1 and irq0_o stays 1.
REQ-038 SHALL be verified by a clearing write to CMCSR1 in the same cycle as cmf1_i=1 -> CMF1=1 afterwards, and a further 0-write without a re-read leaves it 1.
REQ-039 SHALL be verified by asserting rst_n=0 the cycle after an access is accepted -> no ack_o occurs, and const0_o=const1_o=16'hFFFF with all other outputs at 0.

Source files
------------

// File: rtl/cmt_regif.sv
// Register interface for a two-channel compare-match timer: CMSTR, per-channel
// CMCSR/CMCNT/CMCOR, the armed read-then-clear CMF rule and level interrupts.
module cmt_regif #(
    parameter logic [15:0] COR_RST = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [2:0]  addr_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] rdata_o,
    output logic        ack_o,
    output logic        str0_o,
    output logic        str1_o,
    output logic [1:0]  cks0_o,
    output logic [1:0]  cks1_o,
    output logic [15:0] const0_o,
    output logic [15:0] const1_o,
    output logic        set_cnt0_o,
    output logic        set_cnt1_o,
    output logic [15:0] wdata_cnt0_o,
    output logic [15:0] wdata_cnt1_o,
    input  logic        cmf0_i,
    input  logic        cmf1_i,
    input  logic [15:0] cnt0_i,
    input  logic [15:0] cnt1_i,
    output logic        irq0_o,
    output logic        irq1_o
);

    logic        ack_q, ack_d;
    logic [15:0] rdata_q, rdata_d;
    logic [1:0]  str_q, str_d;
    logic        accept, wr, rd;

    logic [1:0]  cmf_in;
    logic [15:0] cnt_in   [2];
    logic [15:0] csr_val  [2];
    logic [15:0] cor_val  [2];
    logic [15:0] wcnt_val [2];
    logic [1:0]  cks_val  [2];
    logic [1:0]  set_cnt_val;
    logic [1:0]  irq_val;

    assign cmf_in    = {cmf1_i, cmf0_i};
    assign cnt_in[0] = cnt0_i;
    assign cnt_in[1] = cnt1_i;

    // The ack cycle itself is never an accept cycle, spacing accesses by 2.
    assign accept = ce_i & ~ack_q;
    assign wr     = accept & we_i;
    assign rd     = accept & ~we_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            localparam logic [2:0] CSR_A = 3'(1 + 3 * gi);
            localparam logic [2:0] CNT_A = 3'(2 + 3 * gi);
            localparam logic [2:0] COR_A = 3'(3 + 3 * gi);

            logic        cmf_q, cmf_d;
            logic        arm_q, arm_d;
            logic        cmie_q, cmie_d;
            logic [1:0]  cks_q, cks_d;
            logic [15:0] cor_q, cor_d;
            logic        set_cnt_q, set_cnt_d;
            logic [15:0] wcnt_q, wcnt_d;
            logic        irq_q, irq_d;
            logic        wr_csr, rd_csr, wr_clr;

            assign wr_csr = wr && (addr_i == CSR_A);
            assign rd_csr = rd && (addr_i == CSR_A);
            assign wr_clr = wr_csr && !wdata_i[7];

            always_comb begin
                cmf_d     = cmf_q;
                arm_d     = arm_q;
                cmie_d    = cmie_q;
                cks_d     = cks_q;
                cor_d     = cor_q;
                set_cnt_d = 1'b0;
                wcnt_d    = wcnt_q;
                if (wr_clr && arm_q)
                    cmf_d = 1'b0;
                // A hardware set always wins over a software clear.
                if (cmf_in[gi])
                    cmf_d = 1'b1;
                if (rd_csr && cmf_q)
                    arm_d = 1'b1;
                if (cmf_in[gi] && (!cmf_q || wr_clr))
                    arm_d = 1'b0;
                if (wr_csr) begin
                    cmie_d = wdata_i[6];
                    cks_d  = wdata_i[1:0];
                end
                if (wr && (addr_i == COR_A))
                    cor_d = wdata_i;
                if (wr && (addr_i == CNT_A)) begin
                    set_cnt_d = 1'b1;
                    wcnt_d    = wdata_i;
                end
                irq_d = cmf_d & cmie_d;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cmf_q     <= 1'b0;
                    arm_q     <= 1'b0;
                    cmie_q    <= 1'b0;
                    cks_q     <= 2'b00;
                    cor_q     <= COR_RST;
                    set_cnt_q <= 1'b0;
                    wcnt_q    <= 16'h0000;
                    irq_q     <= 1'b0;
                end else begin
                    cmf_q     <= cmf_d;
                    arm_q     <= arm_d;
                    cmie_q    <= cmie_d;
                    cks_q     <= cks_d;
                    cor_q     <= cor_d;
                    set_cnt_q <= set_cnt_d;
                    wcnt_q    <= wcnt_d;
                    irq_q     <= irq_d;
                end
            end

            assign csr_val[gi]     = {8'h00, cmf_q, cmie_q, 4'h0, cks_q};
            assign cor_val[gi]     = cor_q;
            assign wcnt_val[gi]    = wcnt_q;
            assign cks_val[gi]     = cks_q;
            assign set_cnt_val[gi] = set_cnt_q;
            assign irq_val[gi]     = irq_q;
        end
    endgenerate

    always_comb begin
        ack_d   = accept;
        str_d   = str_q;
        rdata_d = 16'h0000;
        if (wr && (addr_i == 3'd0))
            str_d = wdata_i[1:0];
        if (rd) begin
            case (addr_i)
                3'd0:    rdata_d = {14'h0000, str_q};
                3'd1:    rdata_d = csr_val[0];
                3'd2:    rdata_d = cnt_in[0];
                3'd3:    rdata_d = cor_val[0];
                3'd4:    rdata_d = csr_val[1];
                3'd5:    rdata_d = cnt_in[1];
                3'd6:    rdata_d = cor_val[1];
                default: rdata_d = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            rdata_q <= 16'h0000;
            str_q   <= 2'b00;
        end else begin
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            str_q   <= str_d;
        end
    end

    assign ack_o        = ack_q;
    assign rdata_o      = rdata_q;
    assign str0_o       = str_q[0];
    assign str1_o       = str_q[1];
    assign cks0_o       = cks_val[0];
    assign cks1_o       = cks_val[1];
    assign const0_o     = cor_val[0];
    assign const1_o     = cor_val[1];
    assign set_cnt0_o   = set_cnt_val[0];
    assign set_cnt1_o   = set_cnt_val[1];
    assign wdata_cnt0_o = wcnt_val[0];
    assign wdata_cnt1_o = wcnt_val[1];
    assign irq0_o       = irq_val[0];
    assign irq1_o       = irq_val[1];

endmodule

// File: tb/tb_cmt_regif.sv
// Directed bench for cmt_regif: bus accesses, counter loads, CMF arm/clear
// behaviour, interrupts, reserved address and reset during an access.
module tb_cmt_regif;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce_i = 1'b0;
    logic        we_i = 1'b0;
    logic [2:0]  addr_i = 3'd0;
    logic [15:0] wdata_i = 16'h0000;
    logic [15:0] rdata_o;
    logic        ack_o;
    logic        str0_o, str1_o;
    logic [1:0]  cks0_o, cks1_o;
    logic [15:0] const0_o, const1_o;
    logic        set_cnt0_o, set_cnt1_o;
    logic [15:0] wdata_cnt0_o, wdata_cnt1_o;
    logic        cmf0_i = 1'b0;
    logic        cmf1_i = 1'b0;
    logic [15:0] cnt0_i = 16'h0000;
    logic [15:0] cnt1_i = 16'h0000;
    logic        irq0_o, irq1_o;

    int checks   = 0;
    int failures = 0;
    logic watch_ack = 1'b0;
    logic ack_seen  = 1'b0;

    always #10 clk = ~clk;

    cmt_regif #(.COR_RST(16'hFFFF)) dut (
        .clk(clk), .rst_n(rst_n), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rdata_o(rdata_o), .ack_o(ack_o),
        .str0_o(str0_o), .str1_o(str1_o), .cks0_o(cks0_o), .cks1_o(cks1_o),
        .const0_o(const0_o), .const1_o(const1_o),
        .set_cnt0_o(set_cnt0_o), .set_cnt1_o(set_cnt1_o),
        .wdata_cnt0_o(wdata_cnt0_o), .wdata_cnt1_o(wdata_cnt1_o),
        .cmf0_i(cmf0_i), .cmf1_i(cmf1_i), .cnt0_i(cnt0_i), .cnt1_i(cnt1_i),
        .irq0_o(irq0_o), .irq1_o(irq1_o)
    );

    always @(negedge clk)
        if (watch_ack && ack_o === 1'b1) ack_seen <= 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns at the negedge inside the ack cycle.
    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        ce_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
        @(negedge clk);
        ce_i = 1'b0; we_i = 1'b0;
        check("wr_ack", {31'h0, ack_o}, 32'h1);
        $display("WR addr=%0d data=%h", a, d);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        ce_i = 1'b1; we_i = 1'b0; addr_i = a;
        @(negedge clk);
        ce_i = 1'b0;
        check("rd_ack", {31'h0, ack_o}, 32'h1);
        d = rdata_o;
        $display("RD addr=%0d data=%h", a, d);
    endtask

    task automatic pulse_cmf(input int ch);
        @(negedge clk);
        if (ch == 0) cmf0_i = 1'b1; else cmf1_i = 1'b1;
        @(negedge clk);
        cmf0_i = 1'b0; cmf1_i = 1'b0;
        $display("CMF pulse ch=%0d", ch);
    endtask

    initial begin
        logic [15:0] rd;

        repeat (3) @(negedge clk);
        check("rst_ack", {31'h0, ack_o}, 32'h0);
        check("rst_const0", {16'h0, const0_o}, 32'hFFFF);
        rst_n = 1'b1;
        @(negedge clk);
        check("init_rdata", {16'h0, rdata_o}, 32'h0);
        check("init_const1", {16'h0, const1_o}, 32'hFFFF);
        check("init_misc", {26'h0, str1_o, str0_o, cks1_o, cks0_o},  32'h0);
        check("init_irq", {30'h0, irq1_o, irq0_o}, 32'h0);

        bus_write(3'd0, 16'h0003);
        check("str_after_wr", {30'h0, str1_o, str0_o}, 32'h3);
        @(negedge clk);
        check("ack_one_cycle", {31'h0, ack_o}, 32'h0);
        bus_read(3'd0, rd);
        check("cmstr_rd", {16'h0, rd}, 32'h0003);
        @(negedge clk);
        check("rdata_idle", {16'h0, rdata_o}, 32'h0);

        bus_write(3'd5, 16'h1234);
        check("set_cnt1", {31'h0, set_cnt1_o}, 32'h1);
        check("wdata_cnt1", {16'h0, wdata_cnt1_o}, 32'h1234);
        check("set_cnt0_idle", {31'h0, set_cnt0_o}, 32'h0);
        @(negedge clk);
        check("set_cnt1_drop", {31'h0, set_cnt1_o}, 32'h0);
        check("wdata_cnt1_hold", {16'h0, wdata_cnt1_o}, 32'h1234);

        cnt0_i = 16'hBEEF;
        bus_read(3'd2, rd);
        check("cnt0_rd", {16'h0, rd}, 32'hBEEF);

        bus_write(3'd3, 16'h00A5);
        check("const0_wr", {16'h0, const0_o}, 32'h00A5);
        bus_write(3'd6, 16'h7777);
        check("const1_wr", {16'h0, const1_o}, 32'h7777);
        bus_read(3'd3, rd);
        check("cor0_rd", {16'h0, rd}, 32'h00A5);

        bus_write(3'd1, 16'h0042);
        check("cks0_wr", {30'h0, cks0_o}, 32'h2);
        check("irq0_idle", {31'h0, irq0_o}, 32'h0);
        pulse_cmf(0);
        check("irq0_set", {31'h0, irq0_o}, 32'h1);
        bus_read(3'd1, rd);
        check("csr0_rd_cmf", {16'h0, rd}, 32'h00C2);
        bus_write(3'd1, 16'h0040);
        check("irq0_cleared", {31'h0, irq0_o}, 32'h0);
        bus_read(3'd1, rd);
        check("csr0_after_clr", {16'h0, rd}, 32'h0040);

        pulse_cmf(0);
        check("irq0_reset2", {31'h0, irq0_o}, 32'h1);
        bus_write(3'd1, 16'h0040);
        check("irq0_unarmed", {31'h0, irq0_o}, 32'h1);
        bus_read(3'd1, rd);
        check("csr0_unarmed", {16'h0, rd}, 32'h00C0);
        bus_write(3'd1, 16'h0040);
        check("irq0_armed_clr", {31'h0, irq0_o}, 32'h0);

        bus_write(3'd4, 16'h0041);
        check("cks1_wr", {30'h0, cks1_o}, 32'h1);
        pulse_cmf(1);
        check("irq1_set", {31'h0, irq1_o}, 32'h1);
        bus_read(3'd4, rd);
        check("csr1_rd_cmf", {16'h0, rd}, 32'h00C1);
        @(negedge clk);
        ce_i = 1'b1; we_i = 1'b1; addr_i = 3'd4; wdata_i = 16'h0040; cmf1_i = 1'b1;
        @(negedge clk);
        ce_i = 1'b0; we_i = 1'b0; cmf1_i = 1'b0;
        $display("WR addr=4 data=0040 with cmf1 pulse");
        check("coinc_ack", {31'h0, ack_o}, 32'h1);
        check("irq1_coinc", {31'h0, irq1_o}, 32'h1);
        bus_write(3'd4, 16'h0040);
        check("irq1_disarmed", {31'h0, irq1_o}, 32'h1);
        bus_read(3'd4, rd);
        check("csr1_still_set", {16'h0, rd}, 32'h00C0);
        check("irq0_indep", {31'h0, irq0_o}, 32'h0);

        bus_write(3'd7, 16'hFFFF);
        bus_read(3'd7, rd);
        check("reserved_rd", {16'h0, rd}, 32'h0);

        @(negedge clk);
        @(negedge clk);
        watch_ack = 1'b1;
        ce_i = 1'b1; we_i = 1'b1; addr_i = 3'd3; wdata_i = 16'h5555;
        #5 rst_n = 1'b0;
        @(negedge clk);
        ce_i = 1'b0; we_i = 1'b0;
        $display("WR addr=3 data=5555 interrupted by reset");
        @(negedge clk);
        check("rst_no_ack", {31'h0, ack_seen}, 32'h0);
        check("rst_consts", {const1_o, const0_o}, 32'hFFFF_FFFF);
        check("rst_bits", {24'h0, str1_o, str0_o, cks1_o, cks0_o, irq1_o, irq0_o}, 32'h0);
        check("rst_setcnt", {30'h0, set_cnt1_o, set_cnt0_o}, 32'h0);
        check("rst_wdata_cnt", {wdata_cnt1_o, wdata_cnt0_o}, 32'h0);
        check("rst_rdata", {16'h0, rdata_o}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_ack", {31'h0, ack_seen}, 32'h0);
        check("post_rst_const0", {16'h0, const0_o}, 32'hFFFF);
        watch_ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
